// File: rtl/mi_arbiter_2p_pkg.sv
// Shared widths and FSM state encoding for the two-port QSPI memory-interface arbiter.
package mi_arbiter_2p_pkg;

    localparam int unsigned MI_AW = 24;
    localparam int unsigned MI_LW = 7;
    localparam int unsigned MI_DW = 32;
    localparam int unsigned SC_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } mi_state_e;

endpackage

// File: rtl/mi_arbiter_2p_pick.sv
// Combinational winner select: round-robin (ARB_MODE=0) or port-1 priority with starvation cap.
module mi_arb_pick
    import mi_arbiter_2p_pkg::*;
#(
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic [1:0]      valid_i,
    input  logic            owner_i,
    input  logic [SC_W-1:0] starve_cnt_i,
    output logic            any_o,
    output logic            win_o
);

    logic capped;

    always_comb begin
        any_o  = |valid_i;
        capped = valid_i[0] && (starve_cnt_i == SC_W'(MAX_STARVE));
        win_o  = 1'b0;
        if (ARB_MODE == 0) begin
            if (valid_i == 2'b11) win_o = ~owner_i;
            else                  win_o = valid_i[1];
        end else begin
            win_o = valid_i[1] && !capped;
        end
    end

endmodule

// File: rtl/mi_arbiter_2p.sv
// Shares the single qpi_memctrl command/data port between cache (port 0) and video DMA (port 1).
module mi_arbiter_2p
    import mi_arbiter_2p_pkg::*;
#(
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                 clk_4x_s,
    input  logic                 rst,
    input  logic [2*MI_AW-1:0]   s_addr,
    input  logic [2*MI_LW-1:0]   s_len,
    input  logic [1:0]           s_rw,
    input  logic [1:0]           s_valid,
    output logic [1:0]           s_ready,
    input  logic [2*MI_DW-1:0]   s_wdata,
    output logic [1:0]           s_wack,
    output logic [1:0]           s_wlast,
    output logic [MI_DW-1:0]     s_rdata,
    output logic [1:0]           s_rstb,
    output logic [1:0]           s_rlast,
    output logic [MI_AW-1:0]     m_addr,
    output logic [MI_LW-1:0]     m_len,
    output logic                 m_rw,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MI_DW-1:0]     m_wdata,
    input  logic                 m_wack,
    input  logic                 m_wlast,
    input  logic [MI_DW-1:0]     m_rdata,
    input  logic                 m_rstb,
    input  logic                 m_rlast,
    output logic                 owner,
    output logic                 busy
);

    mi_state_e        state_q, state_d;
    logic [MI_AW-1:0] m_addr_q, m_addr_d;
    logic [MI_LW-1:0] m_len_q, m_len_d;
    logic             m_rw_q, m_rw_d;
    logic             m_valid_q, m_valid_d;
    logic             owner_q, owner_d;
    logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic             any_req, win;

    mi_arb_pick #(
        .ARB_MODE   (ARB_MODE),
        .MAX_STARVE (MAX_STARVE)
    ) u_pick (
        .valid_i      (s_valid),
        .owner_i      (owner_q),
        .starve_cnt_i (starve_cnt_q),
        .any_o        (any_req),
        .win_o        (win)
    );

    always_ff @(posedge clk_4x_s) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_addr_q     <= '0;
            m_len_q      <= '0;
            m_rw_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            m_addr_q     <= m_addr_d;
            m_len_q      <= m_len_d;
            m_rw_q       <= m_rw_d;
            m_valid_q    <= m_valid_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        m_addr_d     = m_addr_q;
        m_len_d      = m_len_q;
        m_rw_d       = m_rw_q;
        m_valid_d    = m_valid_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        s_ready      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    s_ready[win] = 1'b1;
                    m_addr_d     = win ? s_addr[2*MI_AW-1:MI_AW] : s_addr[MI_AW-1:0];
                    m_len_d      = win ? s_len[2*MI_LW-1:MI_LW]  : s_len[MI_LW-1:0];
                    m_rw_d       = s_rw[win];
                    m_valid_d    = 1'b1;
                    owner_d      = win;
                    state_d      = ST_CMD;
                    // Counts only p1 grants that made a waiting p0 wait; saturates at the cap.
                    if (!win)
                        starve_cnt_d = '0;
                    else if (s_valid[0] && (starve_cnt_q != SC_W'(MAX_STARVE)))
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            ST_CMD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rw_q ? (m_rstb && m_rlast) : (m_wack && m_wlast))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_rstb  = '0;
        s_rlast = '0;
        s_wack  = '0;
        s_wlast = '0;
        if (state_q == ST_DATA) begin
            if (m_rw_q) begin
                s_rstb[owner_q]  = m_rstb;
                s_rlast[owner_q] = m_rlast;
            end else begin
                s_wack[owner_q]  = m_wack;
                s_wlast[owner_q] = m_wlast;
            end
        end
    end

    assign s_rdata = m_rdata;
    assign m_wdata = owner_q ? s_wdata[2*MI_DW-1:MI_DW] : s_wdata[MI_DW-1:0];
    assign m_addr  = m_addr_q;
    assign m_len   = m_len_q;
    assign m_rw    = m_rw_q;
    assign m_valid = m_valid_q;
    assign owner   = owner_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mi_arbiter_2p.sv
// Directed bench: arbiter pick table, single read/write, RR and priority-cap order, stall, reset mid-burst.
module tb_mi_arbiter_2p;

    logic clk_4x_s = 1'b0;
    logic rst;
    always #5 clk_4x_s = ~clk_4x_s;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: round-robin, hand-driven memctrl side (auto responder optional)
    logic [47:0] a_addr;
    logic [13:0] a_len;
    logic [1:0]  a_rw, a_valid, a_s_ready, a_s_wack, a_s_wlast, a_s_rstb, a_s_rlast;
    logic [63:0] a_wdata;
    logic [31:0] a_s_rdata, a_m_wdata, a_rdata;
    logic [23:0] a_m_addr;
    logic [6:0]  a_m_len;
    logic        a_m_rw, a_m_valid, a_owner, a_busy;
    logic        a_auto, a_ready_man, a_rstb_man, a_rlast_man, a_wack, a_wlast;
    logic        a_m_ready, a_m_rstb, a_m_rlast;

    assign a_m_ready = a_auto ? a_m_valid               : a_ready_man;
    assign a_m_rstb  = a_auto ? (a_busy && !a_m_valid)  : a_rstb_man;
    assign a_m_rlast = a_auto ? (a_busy && !a_m_valid)  : a_rlast_man;

    mi_arbiter_2p #(.ARB_MODE(0), .MAX_STARVE(4)) dut0 (
        .clk_4x_s (clk_4x_s), .rst (rst),
        .s_addr (a_addr), .s_len (a_len), .s_rw (a_rw), .s_valid (a_valid),
        .s_ready (a_s_ready), .s_wdata (a_wdata), .s_wack (a_s_wack), .s_wlast (a_s_wlast),
        .s_rdata (a_s_rdata), .s_rstb (a_s_rstb), .s_rlast (a_s_rlast),
        .m_addr (a_m_addr), .m_len (a_m_len), .m_rw (a_m_rw), .m_valid (a_m_valid),
        .m_ready (a_m_ready), .m_wdata (a_m_wdata), .m_wack (a_wack), .m_wlast (a_wlast),
        .m_rdata (a_rdata), .m_rstb (a_m_rstb), .m_rlast (a_m_rlast),
        .owner (a_owner), .busy (a_busy)
    );

    // ---------------- DUT B: priority with cap 4, single-beat read responder
    logic [1:0]  b_valid, b_s_ready, b_s_wack, b_s_wlast, b_s_rstb, b_s_rlast;
    logic [31:0] b_s_rdata, b_m_wdata;
    logic [23:0] b_m_addr;
    logic [6:0]  b_m_len;
    logic        b_m_rw, b_m_valid, b_owner, b_busy, b_m_ready, b_m_beat;

    assign b_m_ready = b_m_valid;
    assign b_m_beat  = b_busy && !b_m_valid;

    mi_arbiter_2p #(.ARB_MODE(1), .MAX_STARVE(4)) dut1 (
        .clk_4x_s (clk_4x_s), .rst (rst),
        .s_addr ({24'h000B01, 24'h000B00}), .s_len (14'd0), .s_rw (2'b11), .s_valid (b_valid),
        .s_ready (b_s_ready), .s_wdata (64'd0), .s_wack (b_s_wack), .s_wlast (b_s_wlast),
        .s_rdata (b_s_rdata), .s_rstb (b_s_rstb), .s_rlast (b_s_rlast),
        .m_addr (b_m_addr), .m_len (b_m_len), .m_rw (b_m_rw), .m_valid (b_m_valid),
        .m_ready (b_m_ready), .m_wdata (b_m_wdata), .m_wack (1'b0), .m_wlast (1'b0),
        .m_rdata (32'd0), .m_rstb (b_m_beat), .m_rlast (b_m_beat),
        .owner (b_owner), .busy (b_busy)
    );

    // ---------------- Stand-alone pick units
    logic [1:0] p_valid;
    logic       p_owner, pk0_any, pk0_win, pk1_any, pk1_win;
    logic [3:0] p_cnt;

    mi_arb_pick #(.ARB_MODE(0), .MAX_STARVE(4)) pk0 (
        .valid_i (p_valid), .owner_i (p_owner), .starve_cnt_i (p_cnt), .any_o (pk0_any), .win_o (pk0_win));
    mi_arb_pick #(.ARB_MODE(1), .MAX_STARVE(4)) pk1 (
        .valid_i (p_valid), .owner_i (p_owner), .starve_cnt_i (p_cnt), .any_o (pk1_any), .win_o (pk1_win));

    typedef struct {
        logic [1:0] valid;
        logic       owner;
        logic [3:0] cnt;
        logic       any;
        logic       w_rr;
        logic       w_pri;
    } pick_vec_t;

    pick_vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_4x_s);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic rr_g   [6];
    logic pr_g   [10];
    logic [3:0] pr_c [10];
    int   n;

    initial begin
        vecs[0] = '{2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{2'b11, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{2'b11, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{2'b11, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{2'b11, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{2'b01, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        a_addr = '0; a_len = '0; a_rw = '0; a_valid = '0; a_wdata = '0; a_rdata = '0;
        a_auto = 1'b0; a_ready_man = 1'b0; a_rstb_man = 1'b0; a_rlast_man = 1'b0;
        a_wack = 1'b0; a_wlast = 1'b0; b_valid = '0;
        p_valid = '0; p_owner = 1'b0; p_cnt = '0;

        // Reset state
        repeat (3) @(posedge clk_4x_s);
        @(negedge clk_4x_s);
        chk("reset_a", {a_busy, a_m_valid, a_m_rw, a_owner, a_m_len, a_m_addr, a_s_ready,
                        a_s_rstb, a_s_rlast, a_s_wack, a_s_wlast}, '0);
        chk("reset_b", {b_busy, b_m_valid, b_owner, b_m_addr, b_s_ready}, '0);
        chk("reset_starve", dut1.starve_cnt_q, '0);
        step();
        rst = 1'b0;

        // Pick unit table
        for (int i = 0; i < 10; i++) begin
            p_valid = vecs[i].valid; p_owner = vecs[i].owner; p_cnt = vecs[i].cnt;
            #1;
            chk($sformatf("pick_vec%0d", i), {pk0_any, pk0_win, pk1_any, pk1_win},
                {vecs[i].any, vecs[i].w_rr, vecs[i].any, vecs[i].w_pri});
        end

        // Test 1: single p0 read, 8 beats
        step();
        a_valid = 2'b01; a_addr = {24'h00F00F, 24'h000100}; a_len = {7'd2, 7'd7}; a_rw = 2'b01;
        @(negedge clk_4x_s);
        chk("t1_ready", a_s_ready, 2'b01);
        step(); a_valid = '0; a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t1_cmd", {a_m_valid, a_m_rw, a_m_len, a_m_addr, a_busy}, {1'b1, 1'b1, 7'd7, 24'h000100, 1'b1});
        step(); a_ready_man = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_rstb_man = 1'b1; a_rlast_man = (i == 7); a_rdata = 32'hA000_0000 + i;
            @(negedge clk_4x_s);
            chk("t1_beat", {a_m_valid, a_s_rstb, a_s_rlast, a_s_rdata},
                {1'b0, 2'b01, (i == 7) ? 2'b01 : 2'b00, 32'hA000_0000 + i});
            step();
        end
        a_rstb_man = 1'b0; a_rlast_man = 1'b0;
        @(negedge clk_4x_s);
        chk("t1_done", {a_busy, a_s_rstb}, '0);

        // Test 2: single p1 write, 4 beats
        step();
        a_valid = 2'b10; a_addr = {24'h00ABCD, 24'h000111}; a_len = {7'd3, 7'd9}; a_rw = 2'b00;
        @(negedge clk_4x_s);
        chk("t2_ready", a_s_ready, 2'b10);
        step(); a_valid = '0; a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t2_cmd", {a_m_valid, a_m_rw, a_m_len, a_m_addr, a_owner}, {1'b1, 1'b0, 7'd3, 24'h00ABCD, 1'b1});
        step(); a_ready_man = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_wdata = {32'h0000_1000 + i, 32'h0000_DEAD}; a_wack = 1'b1; a_wlast = (i == 3);
            @(negedge clk_4x_s);
            chk("t2_beat", {a_m_wdata, a_s_wack, a_s_wlast, a_s_rstb},
                {32'h0000_1000 + i, 2'b10, (i == 3) ? 2'b10 : 2'b00, 2'b00});
            step();
        end
        a_wack = 1'b0; a_wlast = 1'b0; a_wdata = {32'h0000_5A5A, 32'h0000_A5A5};
        @(negedge clk_4x_s);
        chk("t2_done", {a_busy, a_s_wack, a_m_wdata}, {1'b0, 2'b00, 32'h0000_5A5A});

        // Stray strobes while idle
        step();
        a_rstb_man = 1'b1; a_rlast_man = 1'b1; a_wack = 1'b1; a_wlast = 1'b1; a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("stray_fwd", {a_s_rstb, a_s_rlast, a_s_wack, a_s_wlast, a_busy}, '0);
        step();
        a_rstb_man = 1'b0; a_rlast_man = 1'b0; a_wack = 1'b0; a_wlast = 1'b0; a_ready_man = 1'b0;
        @(negedge clk_4x_s);
        chk("stray_idle", {a_busy, a_m_valid}, '0);

        // Test 5: CMD stall, p1 waits until rlast plus one cycle
        step();
        a_valid = 2'b01; a_addr = {24'h000300, 24'h000200}; a_len = {7'd0, 7'd1}; a_rw = 2'b11;
        @(negedge clk_4x_s);
        chk("t5_ready", a_s_ready, 2'b01);
        step(); a_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_4x_s);
            chk("t5_stall", {a_m_valid, a_m_addr, a_s_ready}, {1'b1, 24'h000200, 2'b00});
            step();
        end
        a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t5_accept", a_s_ready, 2'b00);
        step(); a_ready_man = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_rstb_man = 1'b1; a_rlast_man = (i == 1);
            @(negedge clk_4x_s);
            chk("t5_beat", {a_s_ready, a_s_rstb}, {2'b00, 2'b01});
            step();
        end
        a_rstb_man = 1'b0; a_rlast_man = 1'b0;
        @(negedge clk_4x_s);
        chk("t5_p1_grant", a_s_ready, 2'b10);
        step(); a_valid = '0; a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t5_p1_cmd", {a_m_valid, a_m_addr, a_owner}, {1'b1, 24'h000300, 1'b1});
        step(); a_ready_man = 1'b0; a_rstb_man = 1'b1; a_rlast_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t5_p1_beat", {a_s_rstb, a_s_rlast}, {2'b10, 2'b10});
        step(); a_rstb_man = 1'b0; a_rlast_man = 1'b0;

        // Test 6: reset on the 3rd beat of a len=7 read
        a_valid = 2'b01; a_addr = {24'h000999, 24'h000400}; a_len = {7'd0, 7'd7}; a_rw = 2'b01;
        @(negedge clk_4x_s);
        chk("t6_ready", a_s_ready, 2'b01);
        step(); a_valid = '0; a_ready_man = 1'b1;
        step(); a_ready_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_rstb_man = 1'b1;
            if (i == 2) rst = 1'b1;
            step();
        end
        rst = 1'b0; a_rstb_man = 1'b0;
        @(negedge clk_4x_s);
        chk("t6_reset", {a_busy, a_m_valid, a_m_rw, a_owner, a_m_len, a_m_addr, a_s_ready,
                         a_s_rstb, a_s_rlast, a_s_wack, a_s_wlast}, '0);
        step();
        a_valid = 2'b01; a_addr = {24'h000777, 24'h000500}; a_len = '0; a_rw = 2'b01;
        @(negedge clk_4x_s);
        chk("t6_fresh_ready", a_s_ready, 2'b01);
        step(); a_valid = '0; a_ready_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t6_fresh_cmd", {a_m_valid, a_m_addr}, {1'b1, 24'h000500});
        step(); a_ready_man = 1'b0; a_rstb_man = 1'b1; a_rlast_man = 1'b1;
        @(negedge clk_4x_s);
        chk("t6_fresh_beat", {a_s_rstb, a_s_rlast}, {2'b01, 2'b01});
        step(); a_rstb_man = 1'b0; a_rlast_man = 1'b0;
        @(negedge clk_4x_s);
        chk("t6_fresh_done", a_busy, 1'b0);

        // Test 3: round-robin under continuous contention
        step();
        a_auto = 1'b1; a_rw = 2'b11; a_valid = 2'b11;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
            @(negedge clk_4x_s);
            if (a_s_ready != 2'b00) begin
                rr_g[n] = a_s_ready[1];
                n++;
            end
        end
        step(); a_valid = '0;
        for (int k = 0; k < 20 && a_busy; k++) @(negedge clk_4x_s);
        a_auto = 1'b0;
        chk("t3_count", n, 6);
        for (int i = 0; i < n; i++)
            chk($sformatf("t3_grant%0d", i), rr_g[i], (i % 2 == 0) ? 1'b1 : 1'b0);

        // Test 4: priority with starvation cap 4
        step();
        b_valid = 2'b11;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            @(negedge clk_4x_s);
            if (b_s_ready != 2'b00) begin
                pr_g[n] = b_s_ready[1];
                @(negedge clk_4x_s);
                pr_c[n] = dut1.starve_cnt_q;
                n++;
            end
        end
        step(); b_valid = '0;
        chk("t4_count", n, 10);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("t4_grant%0d", i), pr_g[i], (i % 5 == 4) ? 1'b0 : 1'b1);
            chk($sformatf("t4_starve%0d", i), pr_c[i], (i % 5 == 4) ? 4'd0 : 4'((i % 5) + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
